// File: rtl/rdmx_pkg.sv
// Shared RDMX constants: header signature, header field offsets and FSM state encoding.
package rdmx_pkg;

  localparam logic [15:0] RDMX_MAGIC    = 16'h0122;
  localparam int unsigned RDMX_AW       = 64;
  localparam int unsigned HDR_MAGIC_LSB = 0;
  localparam int unsigned HDR_PLEN_LSB  = 16;
  localparam int unsigned HDR_ADDR_LSB  = 32;
  localparam int unsigned HDR_USER_LSB  = 32 + RDMX_AW;

  // Wide enough for ceil(65535 / bytes-per-beat) at any supported data width
  localparam int unsigned BEATS_W = 17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } rdmx_state_t;

endpackage

// File: rtl/rdmx_tkeep_gen.sv
// Packet length to last-beat byte enables and expected data-beat count.
module rdmx_tkeep_gen
  import rdmx_pkg::*;
#(
  parameter int unsigned DW = 512
) (
  input  logic [15:0]        plen,
  output logic [DW/8-1:0]    last_keep,
  output logic [BEATS_W-1:0] exp_beats
);

  localparam int unsigned KW = DW / 8;
  localparam int unsigned RW = $clog2(KW);

  logic [RW-1:0] rem;
  logic [15:0]   whole;

  assign rem   = plen[RW-1:0];
  assign whole = plen >> RW;

  always_comb begin
    last_keep = '0;
    for (int i = 0; i < KW; i++) begin
      last_keep[i] = (rem == '0) || (RW'(i) < rem);
    end
  end

  // A zero-length packet still carries one data beat
  always_comb begin
    exp_beats = BEATS_W'(whole) + BEATS_W'(rem != '0);
    if (plen == 16'd0) exp_beats = BEATS_W'(1);
  end

endmodule

// File: rtl/rdmx_xmit_be.sv
// RDMX transmit back-end: pops PLEN/ADDR together, emits a header beat, then passes DATA through.
module rdmx_xmit_be
  import rdmx_pkg::*;
#(
  parameter int unsigned DW    = 512,
  parameter int unsigned AW    = 64,
  parameter int unsigned UW    = 40,
  parameter logic [15:0] MAGIC = RDMX_MAGIC
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [15:0]     AXIS_PLEN_TDATA,
  input  logic            AXIS_PLEN_TVALID,
  output logic            AXIS_PLEN_TREADY,
  input  logic [AW-1:0]   AXIS_ADDR_TDATA,
  input  logic [UW-1:0]   AXIS_ADDR_TUSER,
  input  logic            AXIS_ADDR_TVALID,
  output logic            AXIS_ADDR_TREADY,
  input  logic [DW-1:0]   AXIS_DATA_TDATA,
  input  logic            AXIS_DATA_TLAST,
  input  logic            AXIS_DATA_TVALID,
  output logic            AXIS_DATA_TREADY,
  output logic [DW-1:0]   M_AXIS_TDATA,
  output logic [DW/8-1:0] M_AXIS_TKEEP,
  output logic            M_AXIS_TLAST,
  output logic            M_AXIS_TVALID,
  input  logic            M_AXIS_TREADY,
  output logic [31:0]     pkt_count,
  output logic            length_error
);

  localparam int unsigned KW       = DW / 8;
  localparam int unsigned CW       = 9;
  localparam int unsigned USER_LSB = HDR_ADDR_LSB + AW;

  rdmx_state_t        state;
  logic [15:0]        plen_q;
  logic [AW-1:0]      addr_q;
  logic [UW-1:0]      user_q;
  logic [CW-1:0]      beat_cnt;
  logic [CW-1:0]      cnt_nxt;
  logic [KW-1:0]      last_keep;
  logic [BEATS_W-1:0] exp_beats;
  logic [DW-1:0]      hdr;
  logic               req_ok;
  logic               data_hs;
  logic               cnt_hit;

  rdmx_tkeep_gen #(.DW(DW)) u_tkeep (
    .plen      (plen_q),
    .last_keep (last_keep),
    .exp_beats (exp_beats)
  );

  assign req_ok  = (state == S_IDLE) && AXIS_PLEN_TVALID && AXIS_ADDR_TVALID;
  assign data_hs = (state == S_DATA) && AXIS_DATA_TVALID && M_AXIS_TREADY;
  assign cnt_nxt = (beat_cnt == '1) ? beat_cnt : beat_cnt + CW'(1);
  assign cnt_hit = (BEATS_W'(cnt_nxt) == exp_beats);

  always_comb begin
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 16] = MAGIC;
    hdr[HDR_PLEN_LSB  +: 16] = plen_q;
    hdr[HDR_ADDR_LSB  +: AW] = addr_q;
    hdr[USER_LSB      +: UW] = user_q;
  end

  // State, latched request fields, beat check and packet counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      plen_q       <= '0;
      addr_q       <= '0;
      user_q       <= '0;
      beat_cnt     <= '0;
      pkt_count    <= '0;
      length_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_ok) begin
          plen_q <= AXIS_PLEN_TDATA;
          addr_q <= AXIS_ADDR_TDATA;
          user_q <= AXIS_ADDR_TUSER;
          state  <= S_HDR;
        end
        S_HDR: if (M_AXIS_TREADY) begin
          beat_cnt <= '0;
          state    <= S_DATA;
        end
        S_DATA: if (data_hs) begin
          beat_cnt <= cnt_nxt;
          if (AXIS_DATA_TLAST) begin
            if (!cnt_hit) length_error <= 1'b1;
            pkt_count <= pkt_count + 32'd1;
            state     <= S_IDLE;
          end else if (cnt_hit) begin
            length_error <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and output steering by state
  always_comb begin
    AXIS_PLEN_TREADY = 1'b0;
    AXIS_ADDR_TREADY = 1'b0;
    AXIS_DATA_TREADY = 1'b0;
    M_AXIS_TDATA     = '0;
    M_AXIS_TKEEP     = '0;
    M_AXIS_TLAST     = 1'b0;
    M_AXIS_TVALID    = 1'b0;
    case (state)
      S_IDLE: begin
        AXIS_PLEN_TREADY = req_ok;
        AXIS_ADDR_TREADY = req_ok;
      end
      S_HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = hdr;
        M_AXIS_TKEEP  = '1;
      end
      S_DATA: begin
        M_AXIS_TVALID    = AXIS_DATA_TVALID;
        M_AXIS_TDATA     = AXIS_DATA_TDATA;
        M_AXIS_TLAST     = AXIS_DATA_TLAST;
        M_AXIS_TKEEP     = AXIS_DATA_TLAST ? last_keep : '1;
        AXIS_DATA_TREADY = M_AXIS_TREADY;
      end
      default: ;
    endcase
  end

endmodule
